// File: rtl/i2c_eeprom_slave_fsm_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C EEPROM slave protocol engine.
//  state_t   : protocol FSM states
//  I2C_ACK   : bus level of an acknowledge bit
//  I2C_NACK  : bus level of a not-acknowledge bit
//  RW_WRITE / RW_READ : value of the R/W bit in the device-address byte
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_WORD_ADDR = 4'd3,
        ST_WORD_ACK  = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // True when the upper seven bits of a received address byte select this slave.
    function automatic logic dev_match(input logic [6:0] addr_hi, input logic [6:0] dev);
        return (addr_hi == dev);
    endfunction

endpackage

// File: rtl/i2c_eeprom_slave_fsm_if.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave_fsm_if
// Bundles the raw I2C bus, the start/stop detector levels and the EEPROM
// storage-array strobes of the slave protocol engine.
//  scl, sda                      : raw bus lines (asynchronous to clk)
//  start_detected, stop_detected : levels from the start/stop detectors
//  sda_oe                        : 1 = slave pulls SDA low
//  mem_addr/mem_wdata/mem_we/mem_re/mem_rdata : storage-array access
//  busy                          : slave is addressed and transferring
// Modports: slave (the protocol engine), master (bus master + array model).
// ---------------------------------------------------------------------------
interface i2c_eeprom_slave_fsm_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              scl;
    logic              sda;
    logic              start_detected;
    logic              stop_detected;
    logic              sda_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  scl, sda, start_detected, stop_detected, mem_rdata,
        output sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
    );

    modport master (
        output scl, sda, start_detected, stop_detected, mem_rdata,
        input  sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
    );
endinterface

// File: rtl/i2c_eeprom_slave_fsm_sync.sv
// ---------------------------------------------------------------------------
// i2c_sync_edge
// Two-flop synchronizer for an asynchronous input plus registered one-clock
// rise/fall pulses. level is aligned with the pulses so a data line sampled
// with level lines up with an edge pulse of a clock line through a twin
// instance.
//  clk, reset_n : system clock, synchronous active-low reset
//  din          : asynchronous input
//  level        : synchronized value (aligned with rise/fall)
//  rise, fall   : one-clock edge pulses
// ---------------------------------------------------------------------------
module i2c_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Synchronizer chain, delayed copy and registered edge pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise_r <= sync_r & ~prev_r;
            fall_r <= ~sync_r & prev_r;
        end
    end

    assign level = prev_r;
    assign rise  = rise_r;
    assign fall  = fall_r;
endmodule

// File: rtl/i2c_eeprom_slave_fsm.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave_fsm
// I2C slave protocol engine for an EEPROM. Receives device address, word
// address and data bytes, acknowledges them by pulling SDA low, serves read
// bytes MSB first, and issues one-clock read/write strobes to the storage
// array with an auto-incrementing word address.
//  clk     : system clock, at least 8x the SCL frequency
//  reset_n : synchronous active-low reset
//  bus     : i2c_eeprom_slave_fsm_if.slave (bus lines, detector levels,
//            sda_oe, storage-array strobes, busy)
// ---------------------------------------------------------------------------
module i2c_eeprom_slave_fsm
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    i2c_eeprom_slave_fsm_if.slave        bus
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic scl_level_s, scl_rise_s, scl_fall_s;
    logic sda_level_s, sda_rise_s, sda_fall_s;
    logic start_level_s, start_ev_s, start_fall_s;
    logic stop_level_s, stop_ev_s, stop_fall_s;

    i2c_sync_edge #(.RST_VAL(1'b1)) u_sync_scl (
        .clk(clk), .reset_n(reset_n), .din(bus.scl),
        .level(scl_level_s), .rise(scl_rise_s), .fall(scl_fall_s));
    i2c_sync_edge #(.RST_VAL(1'b1)) u_sync_sda (
        .clk(clk), .reset_n(reset_n), .din(bus.sda),
        .level(sda_level_s), .rise(sda_rise_s), .fall(sda_fall_s));
    i2c_sync_edge #(.RST_VAL(1'b0)) u_sync_start (
        .clk(clk), .reset_n(reset_n), .din(bus.start_detected),
        .level(start_level_s), .rise(start_ev_s), .fall(start_fall_s));
    i2c_sync_edge #(.RST_VAL(1'b0)) u_sync_stop (
        .clk(clk), .reset_n(reset_n), .din(bus.stop_detected),
        .level(stop_level_s), .rise(stop_ev_s), .fall(stop_fall_s));

    state_t            state_r, state_s;
    state_t            ack_next_r, ack_next_s;   // state entered once the ACK slot ends
    logic              ack_half_r, ack_half_s;   // 0: ACK not yet driven, 1: ACK on the bus
    logic [3:0]        bit_cnt_r, bit_cnt_s;
    logic [7:0]        rx_shift_r, rx_shift_s;
    logic [7:0]        tx_shift_r, tx_shift_s;
    logic [7:0]        rx_byte_s;
    logic              sda_oe_r, sda_oe_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]        mem_wdata_r, mem_wdata_s;
    logic              mem_we_r, mem_we_s;
    logic              mem_re_r, mem_re_s;
    logic              rd_load_r;                // storage data arrives this clk
    logic              busy_r, busy_s;

    logic sync_unused_s;
    assign sync_unused_s = ^{scl_level_s, sda_rise_s, sda_fall_s, start_level_s,
                             start_fall_s, stop_level_s, stop_fall_s, rx_shift_r[7]};

    // Next-state and output decode for the protocol FSM
    always_comb begin
        state_s     = state_r;
        ack_next_s  = ack_next_r;
        ack_half_s  = ack_half_r;
        bit_cnt_s   = bit_cnt_r;
        rx_shift_s  = rx_shift_r;
        sda_oe_s    = sda_oe_r;
        mem_wdata_s = mem_wdata_r;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        busy_s      = busy_r;
        rx_byte_s   = {rx_shift_r[6:0], sda_level_s};

        // The address advances one clock after each write strobe.
        if (mem_we_r) begin
            mem_addr_s = mem_addr_r + ADDR_ONE;
        end else begin
            mem_addr_s = mem_addr_r;
        end

        if (rd_load_r) begin
            tx_shift_s = bus.mem_rdata;
        end else begin
            tx_shift_s = tx_shift_r;
        end

        if (start_ev_s) begin
            // Start (also repeated start) wins over stop and over a coincident SCL edge.
            state_s    = ST_DEV_ADDR;
            bit_cnt_s  = 4'd0;
            ack_half_s = 1'b0;
            sda_oe_s   = 1'b0;
            busy_s     = 1'b0;
        end else if (stop_ev_s) begin
            state_s    = ST_IDLE;
            bit_cnt_s  = 4'd0;
            ack_half_s = 1'b0;
            sda_oe_s   = 1'b0;
            busy_s     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_oe_s = 1'b0;
                end

                ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
                    sda_oe_s = 1'b0;
                    if (scl_rise_s) begin
                        rx_shift_s = rx_byte_s;
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_s  = 4'd0;
                            ack_half_s = 1'b0;
                            if (state_r == ST_DEV_ADDR) begin
                                if (dev_match(rx_byte_s[7:1], DEV_ADDR)) begin
                                    state_s = ST_DEV_ACK;
                                    busy_s  = 1'b1;
                                    if (rx_byte_s[0] == RW_READ) begin
                                        mem_re_s   = 1'b1;
                                        ack_next_s = ST_RD_DATA;
                                    end else begin
                                        ack_next_s = ST_WORD_ADDR;
                                    end
                                end else begin
                                    state_s = ST_WAIT_STOP;
                                end
                            end else if (state_r == ST_WORD_ADDR) begin
                                mem_addr_s = ADDR_W'(rx_byte_s);
                                state_s    = ST_WORD_ACK;
                                ack_next_s = ST_WR_DATA;
                            end else begin
                                mem_wdata_s = rx_byte_s;
                                mem_we_s    = 1'b1;
                                state_s     = ST_WR_ACK;
                                ack_next_s  = ST_WR_DATA;
                            end
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        rx_shift_s = rx_shift_r;
                    end
                end

                ST_DEV_ACK, ST_WORD_ACK, ST_WR_ACK: begin
                    if (scl_fall_s) begin
                        if (!ack_half_r) begin
                            sda_oe_s   = 1'b1;
                            ack_half_s = 1'b1;
                        end else begin
                            ack_half_s = 1'b0;
                            state_s    = ack_next_r;
                            if (ack_next_r == ST_RD_DATA) begin
                                // The ACK-ending fall is also where the first read bit goes out.
                                sda_oe_s   = ~tx_shift_r[7];
                                tx_shift_s = {tx_shift_r[6:0], 1'b0};
                                bit_cnt_s  = 4'd1;
                            end else begin
                                sda_oe_s  = 1'b0;
                                bit_cnt_s = 4'd0;
                            end
                        end
                    end else begin
                        ack_half_s = ack_half_r;
                    end
                end

                ST_RD_DATA: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            sda_oe_s   = 1'b0;
                            bit_cnt_s  = 4'd0;
                            state_s    = ST_RD_ACK;
                            mem_addr_s = mem_addr_r + ADDR_ONE;
                        end else begin
                            sda_oe_s   = ~tx_shift_r[7];
                            tx_shift_s = {tx_shift_r[6:0], 1'b0};
                            bit_cnt_s  = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end

                ST_RD_ACK: begin
                    sda_oe_s = 1'b0;
                    if (scl_rise_s) begin
                        if (sda_level_s == I2C_ACK) begin
                            mem_re_s  = 1'b1;
                            bit_cnt_s = 4'd0;
                            state_s   = ST_RD_DATA;
                        end else begin
                            state_s = ST_WAIT_STOP;
                            busy_s  = 1'b0;
                        end
                    end else begin
                        state_s = ST_RD_ACK;
                    end
                end

                ST_WAIT_STOP: begin
                    sda_oe_s = 1'b0;
                end

                default: begin
                    state_s  = ST_IDLE;
                    sda_oe_s = 1'b0;
                    busy_s   = 1'b0;
                end
            endcase
        end
    end

    // Protocol state, counters, shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ack_next_r  <= ST_IDLE;
            ack_half_r  <= 1'b0;
            bit_cnt_r   <= 4'd0;
            rx_shift_r  <= 8'h00;
            tx_shift_r  <= 8'h00;
            sda_oe_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 8'h00;
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            rd_load_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ack_next_r  <= ack_next_s;
            ack_half_r  <= ack_half_s;
            bit_cnt_r   <= bit_cnt_s;
            rx_shift_r  <= rx_shift_s;
            tx_shift_r  <= tx_shift_s;
            sda_oe_r    <= sda_oe_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_we_r    <= mem_we_s;
            mem_re_r    <= mem_re_s;
            rd_load_r   <= mem_re_r;
            busy_r      <= busy_s;
        end
    end

    assign bus.sda_oe    = sda_oe_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_re    = mem_re_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_i2c_eeprom_slave_fsm.sv
// ---------------------------------------------------------------------------
// tb_i2c_eeprom_slave_fsm
// Bit-banged I2C master plus a simple storage array around the slave engine.
// Expected data comes from a byte-array model of the EEPROM and an address
// pointer that follows the I2C EEPROM rules (write/read auto-increment, wrap).
// ---------------------------------------------------------------------------
module tb_i2c_eeprom_slave_fsm;
    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic reset_n;
    logic sda_drv;

    i2c_eeprom_slave_fsm_if #(.ADDR_W(8)) bus ();

    i2c_eeprom_slave_fsm #(.DEV_ADDR(7'h50), .ADDR_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and slave
    assign bus.sda = sda_drv & ~bus.sda_oe;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  store [256];      // storage array seen by the DUT
    logic [15:0] wr_log [$];       // {addr, data} of every write strobe
    int          re_cnt = 0;
    int          oe_cnt = 0;

    logic [7:0]  ref_mem [256];    // reference EEPROM contents
    logic [7:0]  ref_ptr;          // reference current word address

    // Storage array and strobe monitor
    always @(posedge clk) begin
        if (bus.mem_we) begin
            wr_log.push_back({bus.mem_addr, bus.mem_wdata});
            store[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_re) begin
            re_cnt <= re_cnt + 1;
            bus.mem_rdata <= store[bus.mem_addr];
        end
        if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_drv = b;
        tick(4);
        bus.scl = 1'b1;
        tick(6);
        s = bus.sda;
        tick(2);
        bus.scl = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(ack_bit, s);
    endtask

    task automatic do_start;
        sda_drv = 1'b1;
        tick(4);
        bus.scl = 1'b1;
        tick(4);
        sda_drv = 1'b0;
        bus.start_detected = 1'b1;
        tick(4);
        bus.start_detected = 1'b0;
        tick(2);
        bus.scl = 1'b0;
        tick(4);
    endtask

    task automatic do_stop;
        sda_drv = 1'b0;
        tick(4);
        bus.scl = 1'b1;
        tick(4);
        sda_drv = 1'b1;
        bus.stop_detected = 1'b1;
        tick(4);
        bus.stop_detected = 1'b0;
        tick(4);
    endtask

    task automatic write_txn(input logic [7:0] waddr, input byte_q_t data);
        logic        ack;
        logic [15:0] obs;
        int          base;
        base = wr_log.size();
        do_start;
        send_byte(8'hA0, ack);  chk("wr_dev_ack", ack, 1'b0);
        chk("wr_busy", bus.busy, 1'b1);
        send_byte(waddr, ack);  chk("wr_word_ack", ack, 1'b0);
        foreach (data[i]) begin
            send_byte(data[i], ack);
            chk("wr_data_ack", ack, 1'b0);
        end
        do_stop;
        chk("wr_count", wr_log.size(), base + data.size());
        foreach (data[i]) begin
            obs = (base + i < wr_log.size()) ? wr_log[base + i] : 16'hxxxx;
            chk("wr_strobe", obs, {waddr + 8'(i), data[i]});
            ref_mem[waddr + 8'(i)] = data[i];
        end
        ref_ptr = waddr + 8'(data.size());
        chk("wr_addr_after", bus.mem_addr, ref_ptr);
        chk("wr_busy_after", bus.busy, 1'b0);
        chk("wr_oe_after", bus.sda_oe, 1'b0);
    endtask

    task automatic read_txn(input logic [7:0] raddr, input int n);
        logic       ack;
        logic [7:0] d;
        do_start;
        send_byte(8'hA0, ack);  chk("rd_dev_w_ack", ack, 1'b0);
        send_byte(raddr, ack);  chk("rd_word_ack", ack, 1'b0);
        do_start;
        send_byte(8'hA1, ack);  chk("rd_dev_r_ack", ack, 1'b0);
        chk("rd_busy", bus.busy, 1'b1);
        ref_ptr = raddr;
        for (int i = 0; i < n; i++) begin
            recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
            chk("rd_data", d, ref_mem[ref_ptr]);
            ref_ptr = ref_ptr + 8'd1;
        end
        chk("rd_addr_after", bus.mem_addr, ref_ptr);
        chk("rd_oe_after_nack", bus.sda_oe, 1'b0);
        chk("rd_busy_after_nack", bus.busy, 1'b0);
        do_stop;
    endtask

    initial begin
        byte_q_t    q;
        logic       ack;
        logic       s;
        int         base;
        int         re0;
        int         oe0;
        logic [7:0] a;
        int         n;

        reset_n = 1'b0;
        bus.scl = 1'b1;
        sda_drv = 1'b1;
        bus.start_detected = 1'b0;
        bus.stop_detected  = 1'b0;
        tick(4);
        chk("rst_sda_oe", bus.sda_oe, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_re", bus.mem_re, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 8'h00);
        chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        reset_n = 1'b1;
        tick(4);

        // Single-byte write
        q = {};
        q.push_back(8'h5A);
        write_txn(8'h12, q);

        // Address mismatch: no ACK, no strobes, bus never pulled
        base = wr_log.size();
        re0  = re_cnt;
        oe0  = oe_cnt;
        do_start;
        send_byte(8'hA2, ack);  chk("mis_dev_nack", ack, 1'b1);
        chk("mis_busy", bus.busy, 1'b0);
        send_byte(8'h55, ack);  chk("mis_data_nack", ack, 1'b1);
        do_stop;
        chk("mis_no_we", wr_log.size(), base);
        chk("mis_no_re", re_cnt, re0);
        chk("mis_no_oe", oe_cnt, oe0);

        // Random read of a known byte
        q = {};
        q.push_back(8'hC3);
        write_txn(8'h34, q);
        read_txn(8'h34, 1);

        // Write across the top of the address space, then read it back
        q = {};
        q.push_back(8'h11);
        q.push_back(8'h22);
        write_txn(8'hFF, q);
        read_txn(8'hFF, 2);

        // Randomized write / read-back bursts
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            q = {};
            for (int j = 0; j < n; j++) q.push_back(8'($urandom_range(0, 255)));
            write_txn(a, q);
            read_txn(a, n);
        end

        // Stop after four data bits: partial byte is discarded
        base = wr_log.size();
        do_start;
        send_byte(8'hA0, ack);  chk("part_dev_ack", ack, 1'b0);
        send_byte(8'h77, ack);  chk("part_word_ack", ack, 1'b0);
        for (int j = 0; j < 4; j++) bit_xfer(j[0], s);
        do_stop;
        chk("part_no_we", wr_log.size(), base);
        chk("part_addr", bus.mem_addr, 8'h77);
        chk("part_oe", bus.sda_oe, 1'b0);
        chk("part_busy", bus.busy, 1'b0);

        // Reset while the slave is driving an ACK
        do_start;
        for (int i = 7; i >= 0; i--) begin
            a = 8'hA0;
            bit_xfer(a[i], s);
        end
        sda_drv = 1'b1;
        tick(4);
        bus.scl = 1'b1;
        tick(4);
        chk("ack_oe_before_rst", bus.sda_oe, 1'b1);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_sda_oe", bus.sda_oe, 1'b0);
        chk("mid_rst_mem_addr", bus.mem_addr, 8'h00);
        chk("mid_rst_mem_wdata", bus.mem_wdata, 8'h00);
        chk("mid_rst_mem_we", bus.mem_we, 1'b0);
        chk("mid_rst_mem_re", bus.mem_re, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        reset_n = 1'b1;
        tick(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
